// File: rtl/csr_trap_unit_if.sv
// csr_trap_unit_if: MW-stage decode qualifiers into the CSR/trap unit and the
// unit's responses back to the pipeline.
//
// Qualifier semantics: there is no stall path in either direction. Every cycle
// the unit acts on whatever the pipeline presents. csr_wr commits at the next
// rising edge. valid says the DE slot holds a real instruction that an
// interrupt may replace. epc_taken is a single-cycle redirect the pipeline must
// accept in the same cycle: flush DE and load epc.
interface csr_trap_unit_if #(
    parameter int XLEN = 32
);
    logic [31:0]     inst_mw;
    logic            csr_rd;
    logic            csr_wr;
    logic            is_mret;
    logic            valid;
    logic            br_taken;
    logic [XLEN-1:0] pc_de;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rdata;
    logic [XLEN-1:0] epc;
    logic            epc_taken;

    modport master (
        output inst_mw, csr_rd, csr_wr, is_mret, valid, br_taken, pc_de, rs1_data,
        input  rdata, epc, epc_taken
    );

    modport slave (
        input  inst_mw, csr_rd, csr_wr, is_mret, valid, br_taken, pc_de, rs1_data,
        output rdata, epc, epc_taken
    );
endinterface

// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file, interrupt synchronizers and the
// trap-entry / mret PC redirect for the MW stage.
// Optional build macro: MTVEC_VECTORED_EN enables vectored interrupt dispatch
// (mtvec[1:0]=01 -> target = base + 4*cause). Without it mtvec[1:0] reads 0.
module csr_trap_unit #(
    parameter int XLEN        = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           timer_irq,
    input  logic           ext_irq,
    csr_trap_unit_if.slave bus
);
    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MIP     = 12'h344;

    logic [11:0] addr;
    logic [2:0]  funct3;
    logic [4:0]  zimm;

    assign addr   = bus.inst_mw[31:20];
    assign funct3 = bus.inst_mw[14:12];
    assign zimm   = bus.inst_mw[19:15];

    // Architectural state: only the implemented bits get flops.
    logic            mstatus_mie;
    logic            mstatus_mpie;
    logic            mie_mtie;
    logic            mie_meie;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;

    logic [SYNC_STAGES-1:0] timer_sync;
    logic [SYNC_STAGES-1:0] ext_sync;
    logic                   mtip;
    logic                   meip;

    // Interrupt lines are asynchronous: shift each through a plain flop chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_sync <= '0;
            ext_sync   <= '0;
        end else begin
            timer_sync <= {timer_sync[SYNC_STAGES-2:0], timer_irq};
            ext_sync   <= {ext_sync[SYNC_STAGES-2:0], ext_irq};
        end
    end

    assign mtip = timer_sync[SYNC_STAGES-1];
    assign meip = ext_sync[SYNC_STAGES-1];

    logic [XLEN-1:0] csr_val;

    // Read mux: current value of the addressed CSR, zero for unmapped addresses.
    always_comb begin
        csr_val = '0;
        case (addr)
            ADDR_MSTATUS: begin
                csr_val[3] = mstatus_mie;
                csr_val[7] = mstatus_mpie;
            end
            ADDR_MIE: begin
                csr_val[7]  = mie_mtie;
                csr_val[11] = mie_meie;
            end
            ADDR_MTVEC:  csr_val = mtvec_q;
            ADDR_MEPC:   csr_val = mepc_q;
            ADDR_MCAUSE: csr_val = mcause_q;
            ADDR_MIP: begin
                csr_val[7]  = mtip;
                csr_val[11] = meip;
            end
            default: csr_val = '0;
        endcase
    end

    assign bus.rdata = bus.csr_rd ? csr_val : '0;

    logic [XLEN-1:0] src;
    logic [XLEN-1:0] wdata;
    logic            wr_en;

    // Zicsr read-modify-write: funct3[2] picks zimm, funct3[1:0] picks RW/RS/RC.
    always_comb begin
        src   = funct3[2] ? XLEN'(zimm) : bus.rs1_data;
        wdata = csr_val;
        case (funct3[1:0])
            2'b01:   wdata = src;
            2'b10:   wdata = csr_val | src;
            2'b11:   wdata = csr_val & ~src;
            default: wdata = csr_val;
        endcase
    end

    // RS/RC with a zero rs1/zimm field are pure reads; funct3 x00 is not a CSR op.
    assign wr_en = bus.csr_wr && (funct3[1:0] != 2'b00) && !(funct3[1] && (zimm == 5'd0));

    logic            irq_ext;
    logic            irq_tmr;
    logic            take_irq;
    logic [3:0]      cause;
    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] irq_target;

    assign irq_ext  = meip & mie_meie;
    assign irq_tmr  = mtip & mie_mtie;
    // Blocked interrupts are not remembered; the mip level simply retries.
    assign take_irq = mstatus_mie & (irq_ext | irq_tmr) & bus.valid & ~bus.is_mret & ~bus.br_taken;
    assign cause    = irq_ext ? 4'd11 : 4'd7;

    // Redirect target: mret wins over an interrupt; both are forced off in reset.
    always_comb begin
        trap_base  = {mtvec_q[XLEN-1:2], 2'b00};
        irq_target = trap_base;
`ifdef MTVEC_VECTORED_EN
        if (mtvec_q[1:0] == 2'b01) begin
            irq_target = trap_base + XLEN'({cause, 2'b00});
        end
`endif
        bus.epc_taken = 1'b0;
        bus.epc       = '0;
        if (rst) begin
            if (bus.is_mret) begin
                bus.epc_taken = 1'b1;
                bus.epc       = mepc_q;
            end else if (take_irq) begin
                bus.epc_taken = 1'b1;
                bus.epc       = irq_target;
            end
        end
    end

    // CSR updates; trap entry is assigned last so it overrides a same-cycle
    // write to mstatus/mepc/mcause, while writes to other CSRs still land.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_mtie     <= 1'b0;
            mie_meie     <= 1'b0;
            mtvec_q      <= '0;
            mepc_q       <= '0;
            mcause_q     <= '0;
        end else begin
            if (wr_en) begin
                case (addr)
                    ADDR_MSTATUS: begin
                        mstatus_mie  <= wdata[3];
                        mstatus_mpie <= wdata[7];
                    end
                    ADDR_MIE: begin
                        mie_mtie <= wdata[7];
                        mie_meie <= wdata[11];
                    end
`ifdef MTVEC_VECTORED_EN
                    ADDR_MTVEC:  mtvec_q <= {wdata[XLEN-1:2], (wdata[1] ? 2'b00 : wdata[1:0])};
`else
                    ADDR_MTVEC:  mtvec_q <= {wdata[XLEN-1:2], 2'b00};
`endif
                    ADDR_MEPC:   mepc_q   <= {wdata[XLEN-1:2], 2'b00};
                    ADDR_MCAUSE: mcause_q <= wdata;
                    default: ;
                endcase
            end
            if (take_irq) begin
                mepc_q       <= {bus.pc_de[XLEN-1:2], 2'b00};
                mcause_q     <= {1'b1, {(XLEN-5){1'b0}}, cause};
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else if (bus.is_mret) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_csr_trap_unit.sv
// tb_csr_trap_unit: directed vector table, hand-written interrupt/mret/reset
// sequences and a randomized run against a CSR-level reference model.
module tb_csr_trap_unit;
    localparam int SYNC = 2;
`ifdef MTVEC_VECTORED_EN
    localparam logic [31:0] EXPV     = 32'h0000_012C;
    localparam logic [31:0] MTVEC_RB = 32'h0000_0101;
`else
    localparam logic [31:0] EXPV     = 32'h0000_0100;
    localparam logic [31:0] MTVEC_RB = 32'h0000_0100;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic timer_irq = 1'b0;
    logic ext_irq = 1'b0;

    always #5 clk = ~clk;

    csr_trap_unit_if #(.XLEN(32)) bus_if ();

    csr_trap_unit #(.XLEN(32), .SYNC_STAGES(SYNC)) dut (
        .clk       (clk),
        .rst       (rst),
        .timer_irq (timer_irq),
        .ext_irq   (ext_irq),
        .bus       (bus_if)
    );

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic        rd;
        logic        wr;
        logic        mret;
        logic        vld;
        logic        br;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic        t;
        logic        e;
        logic [31:0] er;
        logic        et;
        logic [31:0] ee;
    } vec_t;

    int checks = 0;
    int failures = 0;
    logic [64:0] exp_q[$];

    function automatic logic [31:0] ci(logic [11:0] a, logic [4:0] f, logic [2:0] f3);
        return {a, f, f3, 5'd1, 7'h73};
    endfunction

    function automatic vec_t mk(string n, logic [31:0] inst, logic rd, logic wr, logic mret,
                                logic vld, logic br, logic [31:0] pc, logic [31:0] rs1,
                                logic t, logic e, logic [31:0] er, logic et, logic [31:0] ee);
        vec_t v;
        v.name = n; v.inst = inst; v.rd = rd; v.wr = wr; v.mret = mret; v.vld = vld;
        v.br = br; v.pc = pc; v.rs1 = rs1; v.t = t; v.e = e; v.er = er; v.et = et; v.ee = ee;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        bus_if.inst_mw  = 32'h0000_0013;
        bus_if.csr_rd   = 1'b0;
        bus_if.csr_wr   = 1'b0;
        bus_if.is_mret  = 1'b0;
        bus_if.valid    = 1'b0;
        bus_if.br_taken = 1'b0;
        bus_if.pc_de    = 32'h0;
        bus_if.rs1_data = 32'h0;
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        bus_if.inst_mw  = v.inst;
        bus_if.csr_rd   = v.rd;
        bus_if.csr_wr   = v.wr;
        bus_if.is_mret  = v.mret;
        bus_if.valid    = v.vld;
        bus_if.br_taken = v.br;
        bus_if.pc_de    = v.pc;
        bus_if.rs1_data = v.rs1;
        timer_irq       = v.t;
        ext_irq         = v.e;
        #2;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string n, input logic [31:0] er, input logic et, input logic [31:0] ee);
        logic [64:0] exp_v;
        logic [64:0] got_v;
        exp_q.push_back({er, et, ee});
        got_v = {bus_if.rdata, bus_if.epc_taken, bus_if.epc};
        exp_v = exp_q.pop_front();
        checks++;
        if (got_v !== exp_v) begin
            failures++;
            $display("FAIL %s: rdata=%h epc_taken=%b epc=%h, expected rdata=%h epc_taken=%b epc=%h",
                     n, got_v[64:33], got_v[32], got_v[31:0], exp_v[64:33], exp_v[32], exp_v[31:0]);
        end
    endtask

    task automatic run_vec(input vec_t v);
        drive(v);
        check(v.name, v.er, v.et, v.ee);
    endtask

    // ---------------- reference model ----------------
    // CSR values held by address; mip is rebuilt from irq levels seen SYNC edges ago.
    logic [31:0] m_csr[logic [11:0]];
    logic        t_hist[$];
    logic        e_hist[$];

    task automatic model_reset();
        m_csr.delete();
        m_csr[12'h300] = 32'h0;
        m_csr[12'h304] = 32'h0;
        m_csr[12'h305] = 32'h0;
        m_csr[12'h341] = 32'h0;
        m_csr[12'h342] = 32'h0;
        t_hist.delete();
        e_hist.delete();
        for (int i = 0; i < SYNC; i++) begin
            t_hist.push_back(1'b0);
            e_hist.push_back(1'b0);
        end
    endtask

    function automatic logic [31:0] m_read(logic [11:0] a);
        if (a == 12'h344) return (32'(e_hist[0]) << 11) | (32'(t_hist[0]) << 7);
        if (m_csr.exists(a)) return m_csr[a];
        return 32'h0;
    endfunction

    function automatic logic [31:0] m_legal(logic [11:0] a, logic [31:0] v);
        case (a)
            12'h300: return v & 32'h88;
            12'h304: return v & 32'h880;
`ifdef MTVEC_VECTORED_EN
            12'h305: return v[1] ? (v & ~32'h3) : v;
`else
            12'h305: return v & ~32'h3;
`endif
            12'h341: return v & ~32'h3;
            default: return v;
        endcase
    endfunction

    task automatic model_step(input vec_t v, output logic [31:0] er, output logic et, output logic [31:0] ee);
        logic [11:0] a;
        logic [2:0]  f3;
        logic [4:0]  fld;
        logic [31:0] old, ms, mi, base, src, nv, tv;
        logic        ext_on, tmr_on, take;
        int          cause, kind;
        a   = v.inst[31:20];
        f3  = v.inst[14:12];
        fld = v.inst[19:15];
        old = m_read(a);
        er  = v.rd ? old : 32'h0;
        ms  = m_csr[12'h300];
        mi  = m_csr[12'h304];
        ext_on = e_hist[0] && mi[11];
        tmr_on = t_hist[0] && mi[7];
        take   = ms[3] && (ext_on || tmr_on) && v.vld && !v.mret && !v.br;
        cause  = ext_on ? 11 : 7;
        tv     = m_csr[12'h305];
        base   = tv & ~32'h3;
        et = 1'b0;
        ee = 32'h0;
        if (v.mret) begin
            et = 1'b1;
            ee = m_csr[12'h341];
        end else if (take) begin
            et = 1'b1;
            ee = base;
`ifdef MTVEC_VECTORED_EN
            if (tv[1:0] == 2'b01) ee = base + 32'(4 * cause);
`endif
        end
        src  = (f3 >= 3'd5) ? 32'(fld) : v.rs1;
        kind = int'(f3) % 4;
        if (v.wr && m_csr.exists(a) && kind != 0 && (kind == 1 || fld != 5'd0)) begin
            nv = (kind == 1) ? src : (kind == 2) ? (old | src) : (old & ~src);
            m_csr[a] = m_legal(a, nv);
        end
        if (take) begin
            m_csr[12'h341] = v.pc & ~32'h3;
            m_csr[12'h342] = 32'h8000_0000 | 32'(cause);
            m_csr[12'h300] = 32'h80;
        end else if (v.mret) begin
            ms = m_csr[12'h300];
            m_csr[12'h300] = 32'h80 | (ms[7] ? 32'h8 : 32'h0);
        end
        t_hist.push_back(v.t);
        e_hist.push_back(v.e);
        void'(t_hist.pop_front());
        void'(e_hist.pop_front());
    endtask

    // ---------------- stimulus ----------------
    vec_t tbl[$];

    initial begin
        logic [31:0] er, ee;
        logic        et, t_lvl, e_lvl;
        vec_t        v;
        logic [11:0] addr_pool[8];

        set_idle();
        addr_pool = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h7C0, 12'h000};

        // Directed table, applied from the reset state with irq lines low.
        tbl.push_back(mk("rw_mtvec",       ci(12'h305, 5'd5, 3'd1), 1,1,0,0,0, 0, 32'h8000_0103, 0,0, 32'h0, 0, 0));
        tbl.push_back(mk("rs_mtvec_x0",    ci(12'h305, 5'd0, 3'd2), 1,1,0,0,0, 0, 32'hFFFF_FFFF, 0,0, 32'h8000_0100, 0, 0));
        tbl.push_back(mk("rs_mtvec_again", ci(12'h305, 5'd0, 3'd2), 1,1,0,0,0, 0, 32'hFFFF_FFFF, 0,0, 32'h8000_0100, 0, 0));
        tbl.push_back(mk("rwi_mepc",       ci(12'h341, 5'h1F, 3'd5), 1,1,0,0,0, 0, 32'h0, 0,0, 32'h0, 0, 0));
        tbl.push_back(mk("rs_mepc",        ci(12'h341, 5'd3, 3'd2), 1,1,0,0,0, 0, 32'h0000_0F00, 0,0, 32'h1C, 0, 0));
        tbl.push_back(mk("rc_mepc",        ci(12'h341, 5'd3, 3'd3), 1,1,0,0,0, 0, 32'h0000_0104, 0,0, 32'hF1C, 0, 0));
        tbl.push_back(mk("rd_mepc",        ci(12'h341, 5'd0, 3'd2), 1,0,0,0,0, 0, 32'h0, 0,0, 32'hE18, 0, 0));
        tbl.push_back(mk("rd_gated",       ci(12'h341, 5'd0, 3'd2), 0,0,0,0,0, 0, 32'h0, 0,0, 32'h0, 0, 0));
        tbl.push_back(mk("rw_mstatus",     ci(12'h300, 5'd1, 3'd1), 1,1,0,0,0, 0, 32'hFFFF_FFF7, 0,0, 32'h0, 0, 0));
        tbl.push_back(mk("rd_mstatus",     ci(12'h300, 5'd0, 3'd2), 1,0,0,0,0, 0, 32'h0, 0,0, 32'h80, 0, 0));
        tbl.push_back(mk("rw_unmapped",    ci(12'h7C0, 5'd1, 3'd1), 1,1,0,0,0, 0, 32'h1234, 0,0, 32'h0, 0, 0));
        tbl.push_back(mk("rd_unmapped",    ci(12'h7C0, 5'd0, 3'd2), 1,0,0,0,0, 0, 32'h0, 0,0, 32'h0, 0, 0));
        tbl.push_back(mk("mret",           32'h3020_0073,           0,0,1,1,0, 0, 32'h0, 0,0, 32'h0, 1, 32'hE18));
        tbl.push_back(mk("rd_mstatus_mret", ci(12'h300, 5'd0, 3'd2), 1,0,0,0,0, 0, 32'h0, 0,0, 32'h88, 0, 0));
        tbl.push_back(mk("rci_mstatus",    ci(12'h300, 5'd8, 3'd7), 1,1,0,0,0, 0, 32'h0, 0,0, 32'h88, 0, 0));
        tbl.push_back(mk("rd_mstatus_rci", ci(12'h300, 5'd0, 3'd2), 1,0,0,0,0, 0, 32'h0, 0,0, 32'h80, 0, 0));
        tbl.push_back(mk("rw_mcause",      ci(12'h342, 5'd1, 3'd1), 1,1,0,0,0, 0, 32'hDEAD_BEEF, 0,0, 32'h0, 0, 0));
        tbl.push_back(mk("rd_mcause",      ci(12'h342, 5'd0, 3'd2), 1,0,0,0,0, 0, 32'h0, 0,0, 32'hDEAD_BEEF, 0, 0));
        tbl.push_back(mk("rw_mip",         ci(12'h344, 5'd1, 3'd1), 1,1,0,0,0, 0, 32'hFFFF_FFFF, 0,0, 32'h0, 0, 0));
        tbl.push_back(mk("rd_mip",         ci(12'h344, 5'd0, 3'd2), 1,0,0,0,0, 0, 32'h0, 0,0, 32'h0, 0, 0));
        tbl.push_back(mk("f3_000_mie",     ci(12'h304, 5'd5, 3'd0), 1,1,0,0,0, 0, 32'hFFFF_FFFF, 0,0, 32'h0, 0, 0));
        tbl.push_back(mk("rd_mie_0",       ci(12'h304, 5'd0, 3'd2), 1,0,0,0,0, 0, 32'h0, 0,0, 32'h0, 0, 0));
        tbl.push_back(mk("rs_mie",         ci(12'h304, 5'd1, 3'd2), 1,1,0,0,0, 0, 32'hFFFF_FFFF, 0,0, 32'h0, 0, 0));
        tbl.push_back(mk("rd_mie",         ci(12'h304, 5'd0, 3'd2), 1,0,0,0,0, 0, 32'h0, 0,0, 32'h880, 0, 0));
        tbl.push_back(mk("rwi_zero_mcause", ci(12'h342, 5'd0, 3'd5), 1,1,0,0,0, 0, 32'h0, 0,0, 32'hDEAD_BEEF, 0, 0));
        tbl.push_back(mk("rd_mcause_zero", ci(12'h342, 5'd0, 3'd2), 1,0,0,0,0, 0, 32'h0, 0,0, 32'h0, 0, 0));

        // Reset held: outputs stay quiet even with mret and a read presented.
        repeat (2) @(negedge clk);
        bus_if.inst_mw = ci(12'h305, 5'd0, 3'd2);
        bus_if.csr_rd  = 1'b1;
        bus_if.is_mret = 1'b1;
        bus_if.valid   = 1'b1;
        #2;
        check("rst_hold", 32'h0, 1'b0, 32'h0);
        set_idle();
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

        // Timer interrupt: visible after two synchronizer edges, then trap entry.
        run_vec(mk("a_mstatus_mie", ci(12'h300, 5'd8, 3'd5), 1,1,0,0,0, 0, 0, 0,0, 32'h80, 0, 0));
        run_vec(mk("a_sync0", 32'h13, 0,0,0,1,0, 32'h40, 0, 1,0, 0, 0, 0));
        run_vec(mk("a_sync1", 32'h13, 0,0,0,1,0, 32'h40, 0, 1,0, 0, 0, 0));
        run_vec(mk("a_take",  32'h13, 0,0,0,1,0, 32'h40, 0, 1,0, 0, 1, 32'h8000_0100));
        run_vec(mk("a_mepc",    ci(12'h341, 5'd0, 3'd2), 1,0,0,0,0, 0, 0, 1,0, 32'h40, 0, 0));
        run_vec(mk("a_mcause",  ci(12'h342, 5'd0, 3'd2), 1,0,0,0,0, 0, 0, 1,0, 32'h8000_0007, 0, 0));
        run_vec(mk("a_mstatus", ci(12'h300, 5'd0, 3'd2), 1,0,0,0,0, 0, 0, 1,0, 32'h80, 0, 0));
        run_vec(mk("a_mip_hi",  ci(12'h344, 5'd0, 3'd2), 1,0,0,0,0, 0, 0, 1,0, 32'h80, 0, 0));
        run_vec(mk("a_mip_d0",  ci(12'h344, 5'd0, 3'd2), 1,0,0,0,0, 0, 0, 0,0, 32'h80, 0, 0));
        run_vec(mk("a_mip_d1",  ci(12'h344, 5'd0, 3'd2), 1,0,0,0,0, 0, 0, 0,0, 32'h80, 0, 0));
        run_vec(mk("a_mip_lo",  ci(12'h344, 5'd0, 3'd2), 1,0,0,0,0, 0, 0, 0,0, 32'h0, 0, 0));

        // Blocking conditions, mret priority, dropped mstatus write, re-take after mret.
        run_vec(mk("b_rw_mtvec", ci(12'h305, 5'd1, 3'd1), 1,1,0,0,0, 0, 32'h101, 0,0, 32'h8000_0100, 0, 0));
        run_vec(mk("b_mret0",   32'h3020_0073, 0,0,1,0,0, 0, 0, 0,0, 0, 1, 32'h40));
        run_vec(mk("b_novld0",  32'h13, 0,0,0,0,0, 32'h60, 0, 1,1, 0, 0, 0));
        run_vec(mk("b_novld1",  32'h13, 0,0,0,0,0, 32'h60, 0, 1,1, 0, 0, 0));
        run_vec(mk("b_novld2",  32'h13, 0,0,0,0,0, 32'h60, 0, 1,1, 0, 0, 0));
        run_vec(mk("b_br",      32'h13, 0,0,0,1,1, 32'h60, 0, 1,1, 0, 0, 0));
        run_vec(mk("b_mret_pri", 32'h3020_0073, 0,0,1,1,0, 32'h60, 0, 1,1, 0, 1, 32'h40));
        run_vec(mk("b_take_rc", ci(12'h300, 5'd3, 3'd3), 1,1,0,1,0, 32'h80, 32'h8, 1,1, 32'h88, 1, EXPV));
        run_vec(mk("b_mstatus", ci(12'h300, 5'd0, 3'd2), 1,0,0,0,0, 0, 0, 1,1, 32'h80, 0, 0));
        run_vec(mk("b_mcause",  ci(12'h342, 5'd0, 3'd2), 1,0,0,0,0, 0, 0, 1,1, 32'h8000_000B, 0, 0));
        run_vec(mk("b_mepc",    ci(12'h341, 5'd0, 3'd2), 1,0,0,0,0, 0, 0, 1,1, 32'h80, 0, 0));
        run_vec(mk("b_mtvec",   ci(12'h305, 5'd0, 3'd2), 1,0,0,0,0, 0, 0, 1,1, MTVEC_RB, 0, 0));
        run_vec(mk("b_mret1",   32'h3020_0073, 0,0,1,0,0, 0, 0, 1,1, 0, 1, 32'h80));
        run_vec(mk("b_mstatus2", ci(12'h300, 5'd0, 3'd2), 1,0,0,0,0, 0, 0, 1,1, 32'h88, 0, 0));
        run_vec(mk("b_retake",  32'h13, 0,0,0,1,0, 32'hC0, 0, 1,1, 0, 1, EXPV));

        // Asynchronous reset mid-cycle with mret and a read in flight.
        drive(mk("pre_rst", ci(12'h342, 5'd0, 3'd2), 1,0,1,1,0, 32'h100, 0, 1,1, 0, 0, 0));
        check("pre_rst", 32'h8000_000B, 1'b1, 32'hC0);
        rst = 1'b0;
        #1;
        check("async_rst", 32'h0, 1'b0, 32'h0);
        set_idle();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_vec(mk("r_mip_resync", ci(12'h344, 5'd0, 3'd2), 1,0,0,0,0, 0, 0, 1,1, 32'h0, 0, 0));
        run_vec(mk("r_mip_back",   ci(12'h344, 5'd0, 3'd2), 1,0,0,0,0, 0, 0, 1,1, 32'h880, 0, 0));
        run_vec(mk("r_mcause", ci(12'h342, 5'd0, 3'd2), 1,0,0,0,0, 0, 0, 1,1, 32'h0, 0, 0));
        run_vec(mk("r_mepc",   ci(12'h341, 5'd0, 3'd2), 1,0,0,0,0, 0, 0, 1,1, 32'h0, 0, 0));
        run_vec(mk("r_mtvec",  ci(12'h305, 5'd0, 3'd2), 1,0,0,0,0, 0, 0, 1,1, 32'h0, 0, 0));
        run_vec(mk("r_mstatus", ci(12'h300, 5'd0, 3'd2), 1,0,0,0,0, 0, 0, 1,1, 32'h0, 0, 0));
        run_vec(mk("r_mie",    ci(12'h304, 5'd0, 3'd2), 1,0,0,1,0, 32'h4, 0, 1,1, 32'h0, 0, 0));

        // Randomized run against the reference model, from a fresh reset.
        @(negedge clk);
        set_idle();
        timer_irq = 1'b0;
        ext_irq   = 1'b0;
        rst       = 1'b0;
        repeat (SYNC + 1) @(negedge clk);
        rst = 1'b1;
        model_reset();
        t_lvl = 1'b0;
        e_lvl = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            logic [4:0] fld;
            if ($urandom_range(0, 19) == 0) t_lvl = ~t_lvl;
            if ($urandom_range(0, 19) == 0) e_lvl = ~e_lvl;
            fld = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            v = mk($sformatf("rand_%0d", i),
                   ci(addr_pool[$urandom_range(0, 7)], fld, 3'($urandom_range(0, 7))),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 7) == 0), $urandom(), $urandom(),
                   t_lvl, e_lvl, 0, 0, 0);
            if (v.mret) v.wr = 1'b0;
            drive(v);
            model_step(v, er, et, ee);
            check(v.name, er, et, ee);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
